mouse_receiver: RTL and testbench

PS/2 receive stage directly upstream of the mouse master state machine. Synchronises the open-collector mouse clock and data lines, deframes 11-bit device-to-host frames (start, 8 data bits LSB first, odd parity, stop) and presents each byte with an error code and a one-cycle ready strobe. Receives only while the master state machine enables it. Aborts stalled frames with a timeout.

---
 rtl/mouse_pkg.sv | 21 ++
 rtl/ps2_line_sync.sv | 30 +++
 rtl/mouse_receiver.sv | 144 ++++++++++++++
 tb/tb_mouse_receiver.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mouse_pkg.sv
// Shared definitions for the PS/2 mouse receive/transmit path: receiver
// states, error-code encodings and frame geometry.
package mouse_pkg;

  typedef enum logic [2:0] {
    IDLE,
    DATA,
    PARITY,
    STOP,
    DONE
  } rx_state_e;

  localparam logic [1:0] ERR_NONE   = 2'b00;
  localparam logic [1:0] ERR_PARITY = 2'b01;
  localparam logic [1:0] ERR_STOP   = 2'b10;

  // start + 8 data + parity + stop
  localparam int PS2_FRAME_BITS = 11;
  localparam int PS2_DATA_BITS  = PS2_FRAME_BITS - 3;

endpackage

// File: rtl/ps2_line_sync.sv
// Two-flop synchroniser for an open-collector PS/2 line plus a falling-edge
// detector on the synchronised level. Idles high to match the pulled-up bus.
module ps2_line_sync (
  input  logic clk_i,
  input  logic reset_i,
  input  logic line_i,
  output logic level_o,
  output logic fall_o
);

  logic meta_q;
  logic sync_q;
  logic prev_q;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
      prev_q <= 1'b1;
    end else begin
      meta_q <= line_i;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign level_o = sync_q;
  assign fall_o  = prev_q & ~sync_q;

endmodule

// File: rtl/mouse_receiver.sv
// PS/2 device-to-host receiver: deframes start/8 data/odd parity/stop frames
// clocked by the mouse, reports each byte with an error code and a one-cycle
// ready strobe, and abandons frames whose mouse clock stalls.
module mouse_receiver
  import mouse_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 200000,
  parameter int TIMER_W        = 18
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       CLK_MOUSE_IN,
  input  logic       DATA_MOUSE_IN,
  input  logic       READ_ENABLE,
  output logic [7:0] BYTE_READ,
  output logic [1:0] BYTE_ERROR_CODE,
  output logic       BYTE_READY
);

  logic mouseFall;
  logic mouseData;
  logic unusedClkLevel;
  logic unusedDataFall;

  ps2_line_sync uClkSync (
    .clk_i   (CLK),
    .reset_i (RESET),
    .line_i  (CLK_MOUSE_IN),
    .level_o (unusedClkLevel),
    .fall_o  (mouseFall)
  );

  ps2_line_sync uDataSync (
    .clk_i   (CLK),
    .reset_i (RESET),
    .line_i  (DATA_MOUSE_IN),
    .level_o (mouseData),
    .fall_o  (unusedDataFall)
  );

  rx_state_e          state_q, state_d;
  logic [7:0]         shift_q, shift_d;
  logic [2:0]         bitCount_q, bitCount_d;
  logic               parity_q, parity_d;
  logic [TIMER_W-1:0] timer_q, timer_d;
  logic [7:0]         byteRead_q, byteRead_d;
  logic [1:0]         errCode_q, errCode_d;
  logic               ready_q, ready_d;
  logic               timeout;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q    <= IDLE;
      shift_q    <= '0;
      bitCount_q <= '0;
      parity_q   <= 1'b0;
      timer_q    <= '0;
      byteRead_q <= 8'h00;
      errCode_q  <= ERR_NONE;
      ready_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      bitCount_q <= bitCount_d;
      parity_q   <= parity_d;
      timer_q    <= timer_d;
      byteRead_q <= byteRead_d;
      errCode_q  <= errCode_d;
      ready_q    <= ready_d;
    end
  end

  assign timeout = (timer_q == TIMER_W'(TIMEOUT_CYCLES - 1));

  // Outputs are registered on the stop-bit edge so they, and the strobe,
  // are visible during the single DONE cycle.
  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    bitCount_d = bitCount_q;
    parity_d   = parity_q;
    timer_d    = timer_q;
    byteRead_d = byteRead_q;
    errCode_d  = errCode_q;
    ready_d    = 1'b0;

    case (state_q)
      IDLE: begin
        timer_d = '0;
        if (mouseFall && READ_ENABLE && !mouseData) begin
          state_d    = DATA;
          shift_d    = '0;
          bitCount_d = '0;
        end
      end

      DATA, PARITY, STOP: begin
        if (mouseFall) begin
          timer_d = '0;
          case (state_q)
            DATA: begin
              shift_d    = {mouseData, shift_q[7:1]};
              bitCount_d = bitCount_q + 3'd1;
              if (bitCount_q == 3'(PS2_DATA_BITS - 1)) begin
                state_d = PARITY;
              end
            end
            PARITY: begin
              parity_d = mouseData;
              state_d  = STOP;
            end
            default: begin
              byteRead_d = shift_q;
              errCode_d  = ((~^{shift_q, parity_q}) ? ERR_PARITY : ERR_NONE) |
                           ((!mouseData) ? ERR_STOP : ERR_NONE);
              ready_d    = 1'b1;
              state_d    = DONE;
            end
          endcase
        end else if (timeout) begin
          // Stalled frame: drop the partial byte, leave outputs untouched.
          timer_d = '0;
          state_d = IDLE;
        end else begin
          timer_d = timer_q + TIMER_W'(1);
        end
      end

      DONE: begin
        timer_d = '0;
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign BYTE_READ       = byteRead_q;
  assign BYTE_ERROR_CODE = errCode_q;
  assign BYTE_READY      = ready_q;

endmodule

// File: tb/tb_mouse_receiver.sv
// Bench for mouse_receiver: drives PS/2 frames on the pins and checks every
// cycle against a frame-level model of what the mouse has sent.
module tb_mouse_receiver;

  localparam int T = 100;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       clkPin = 1'b1;
  logic       dataPin = 1'b1;
  logic       readEnable = 1'b0;
  logic [7:0] byteRead;
  logic [1:0] errCode;
  logic       ready;

  int total = 0;
  int bad = 0;
  int cyc = 0;

  typedef struct {
    logic [7:0] b;
    logic [1:0] e;
  } exp_t;

  exp_t       expQ[$];
  logic [7:0] lastByte = 8'h00;
  logic [1:0] lastErr = 2'b00;
  logic       prevReady = 1'b0;
  int         mCount = -1;
  int         lastFall = 0;
  logic [9:0] mBits = '0;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  mouse_receiver #(
    .TIMEOUT_CYCLES (T),
    .TIMER_W        (18)
  ) dut (
    .CLK             (clk),
    .RESET           (reset),
    .CLK_MOUSE_IN    (clkPin),
    .DATA_MOUSE_IN   (dataPin),
    .READ_ENABLE     (readEnable),
    .BYTE_READ       (byteRead),
    .BYTE_ERROR_CODE (errCode),
    .BYTE_READY      (ready)
  );

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0h, expected %0h at cycle %0d", name, actual, expected, cyc);
    end
  endtask

  // Frame-level model: the mouse's bit stream after a valid start bit, with
  // a frame abandoned if the clock gap exceeds the timeout.
  function automatic void modelEdge(input logic d);
    exp_t e;
    if (mCount >= 0 && (cyc - lastFall) > T) mCount = -1;
    lastFall = cyc;
    if (mCount < 0) begin
      if (readEnable && !d) mCount = 0;
    end else begin
      mBits[mCount] = d;
      mCount++;
      if (mCount == 10) begin
        e.b = mBits[7:0];
        e.e[0] = ($countones(mBits[8:0]) % 2) == 0;
        e.e[1] = !mBits[9];
        expQ.push_back(e);
        mCount = -1;
      end
    end
  endfunction

  function automatic logic [10:0] makeFrame(input logic [7:0] b, input logic parOk,
                                            input logic stop);
    logic p;
    p = ($countones(b) % 2) == 0;
    if (!parOk) p = ~p;
    return {stop, p, b, 1'b0};
  endfunction

  // Per-cycle comparison against the model once reset is released.
  always @(negedge clk) begin : compare
    exp_t e;
    if (reset) begin
      prevReady = 1'b0;
    end else begin
      if (ready) begin
        checkOutput("readyBackToBack", 32'(prevReady), 32'd0);
        total++;
        if (expQ.size() == 0) begin
          bad++;
          $display("[TB] FAIL spuriousReady: got ready=1 byte=%0h err=%0h, expected no strobe at cycle %0d",
                   byteRead, errCode, cyc);
        end else begin
          e = expQ.pop_front();
          checkOutput("byte", 32'(byteRead), 32'(e.b));
          checkOutput("err", 32'(errCode), 32'(e.e));
          lastByte = e.b;
          lastErr = e.e;
        end
      end else begin
        checkOutput("holdByte", 32'(byteRead), 32'(lastByte));
        checkOutput("holdErr", 32'(errCode), 32'(lastErr));
      end
      prevReady = ready;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic sendBit(input logic d, input int gap, input int enSet);
    tick(gap / 2);
    clkPin = 1'b1;
    tick(gap / 4);
    dataPin = d;
    if (enSet >= 0) readEnable = enSet[0];
    tick(gap - gap / 2 - gap / 4);
    clkPin = 1'b0;
    modelEdge(d);
  endtask

  task automatic endFrame();
    tick(4);
    clkPin = 1'b1;
    tick(2);
    dataPin = 1'b1;
  endtask

  task automatic applyStimulus(input logic [10:0] bits, input int nBits, input int gap,
                               input int enRiseIdx = -1, input int longIdx = -1,
                               input int longGap = 0);
    for (int i = 0; i < nBits; i++) begin
      sendBit(bits[i], (i == longIdx) ? longGap : gap, (i == enRiseIdx) ? 1 : -1);
    end
    endFrame();
  endtask

  task automatic waitDrain();
    int n = 0;
    while (expQ.size() != 0 && n < 20) begin
      tick(1);
      n++;
    end
    tick(2);
    checkOutput("drainPending", 32'(expQ.size()), 32'd0);
  endtask

  task automatic resetDut();
    reset = 1'b1;
    expQ.delete();
    mCount = -1;
    lastByte = 8'h00;
    lastErr = 2'b00;
    tick(3);
    reset = 1'b0;
    tick(1);
  endtask

  initial begin : watchdog
    #5_000_000;
    $display("[TB] FAIL watchdog: got no completion, expected finish before time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : stimulus
    int n;
    int gap;
    resetDut();
    checkOutput("resetByte", 32'(byteRead), 32'h00);
    checkOutput("resetErr", 32'(errCode), 32'h0);
    checkOutput("resetReady", 32'(ready), 32'h0);

    readEnable = 1'b1;
    applyStimulus({1'b1, 1'b1, 8'hFA, 1'b0}, 11, 10);
    waitDrain();
    checkOutput("litFA", 32'(byteRead), 32'hFA);
    checkOutput("litFAerr", 32'(errCode), 32'h0);

    applyStimulus({1'b1, 1'b1, 8'h08, 1'b0}, 11, 10);
    waitDrain();
    checkOutput("lit08", 32'(byteRead), 32'h08);
    checkOutput("lit08err", 32'(errCode), 32'h1);

    applyStimulus({1'b0, 1'b1, 8'hAA, 1'b0}, 11, 12);
    waitDrain();
    checkOutput("litAAstopErr", 32'(errCode), 32'h2);

    applyStimulus({1'b0, 1'b0, 8'hAA, 1'b0}, 11, 12);
    waitDrain();
    checkOutput("litAAbothErr", 32'(errCode), 32'h3);
    checkOutput("litAAbyte", 32'(byteRead), 32'hAA);

    // Stalled frame then a clean one.
    applyStimulus({1'b1, 1'b1, 8'h33, 1'b0}, 5, 10);
    tick(2 * T);
    waitDrain();
    applyStimulus({1'b1, 1'b1, 8'h55, 1'b0}, 11, 10);
    waitDrain();
    checkOutput("lit55", 32'(byteRead), 32'h55);
    checkOutput("lit55err", 32'(errCode), 32'h0);

    // Disabled frame, then enable raised partway through a frame.
    readEnable = 1'b0;
    applyStimulus({1'b1, 1'b1, 8'hFA, 1'b0}, 11, 10);
    tick(15);
    applyStimulus({1'b1, 1'b1, 8'hFA, 1'b0}, 11, 10, 2);
    tick(2 * T);
    waitDrain();
    checkOutput("disabledHold", 32'(byteRead), 32'h55);

    // Reset after the 5th data bit.
    readEnable = 1'b1;
    applyStimulus({1'b1, 1'b0, 8'hF4, 1'b0}, 6, 10);
    resetDut();
    checkOutput("midResetByte", 32'(byteRead), 32'h00);
    checkOutput("midResetErr", 32'(errCode), 32'h0);
    applyStimulus({1'b1, 1'b0, 8'hF4, 1'b0}, 11, 10);
    waitDrain();
    checkOutput("litF4", 32'(byteRead), 32'hF4);
    checkOutput("litF4err", 32'(errCode), 32'h0);

    // Clock gaps just inside and just outside the timeout.
    applyStimulus(makeFrame(8'h3C, 1'b1, 1'b1), 11, 10, -1, 4, T - 5);
    waitDrain();
    checkOutput("lit3C", 32'(byteRead), 32'h3C);
    applyStimulus(makeFrame(8'hC3, 1'b1, 1'b1), 11, 10, -1, 4, T + 5);
    tick(2 * T);
    waitDrain();
    checkOutput("lateEdgeHold", 32'(byteRead), 32'h3C);

    for (int k = 0; k < 40; k++) begin
      readEnable = ($urandom_range(0, 9) != 0);
      gap = $urandom_range(8, 20);
      n = ($urandom_range(0, 9) == 0) ? $urandom_range(1, 10) : 11;
      applyStimulus(makeFrame(8'($urandom), $urandom_range(0, 4) != 0,
                              $urandom_range(0, 4) != 0), n, gap);
      tick((n < 11) ? 2 * T : 15);
      waitDrain();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
